pcap_stim_gen: RTL
==================

Name: pcap_stim_gen

Overview:
- Parametrised, registered generator of framed enable/capture pulse trains on a TTL-style output bus.
- Successor to the fixed enable/capture stimulus used for position-capture framing tests.
- Adds the following:
  - programmable frame count, pre-delay, pulse count, period, width and inter-frame gap;
  - configurable bus width and channel mapping;
  - abort and error reporting.
- Sits between a register/AXI slave (config, start/abort) and the TTL input pads of the panda_top bench or a loopback path.

Parameters:
- CW, 32: width of all counters and config fields.
- N_TTL, 6: width of ttl_o.
- EN_IDX, 0: ttl_o bit carrying enable.
- CAP_IDX, 2: ttl_o bit carrying capture. Must differ from EN_IDX and be < N_TTL; violation is an elaboration error.

Ports:
- clk_i  in  1  system clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- start_i  in  1  single-cycle start request.
- abort_i  in  1  single-cycle abort request.
- nframes_i  in  CW  frames to emit; 0 = run until abort.
- pre_delay_i  in  CW  cycles with enable low before first frame.
- pulses_i  in  CW  capture pulses per frame.
- period_i  in  CW  capture period in cycles.
- width_i  in  CW  capture high time in cycles.
- gap_i  in  CW  enable-low cycles between frames.
- ttl_o  out  N_TTL  bus; enable and capture on the mapped bits, all other bits 0.
- enable_o  out  1  enable (frame) gate.
- capture_o  out  1  capture pulse.
- busy_o  out  1  high from accepted start until return to IDLE.
- done_o  out  1  one-cycle pulse on normal completion.
- err_o  out  1  one-cycle pulse on rejected start.
- frame_cnt_o  out  CW  frames completed in the current run.

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM in IDLE, counters 0.
- All outputs are registered. ttl_o[EN_IDX] = enable_o and ttl_o[CAP_IDX] = capture_o exactly, with no extra delay.
- Config is latched only on an accepted start. Inputs may change freely afterwards.

Start acceptance:
- start_i is accepted in IDLE only when all hold: period >= 2, 1 <= width < period, pulses >= 1, gap >= 1.
- Otherwise err_o pulses the next cycle and the FSM stays in IDLE.
- start_i outside IDLE is ignored and does not raise err_o.
- On accept: frame_cnt_o clears to 0 and busy_o rises the next cycle.

FSM: IDLE -> PRE -> FRAME -> GAP -> (FRAME | DONE) -> IDLE.
- PRE:
  - Lasts pre_delay cycles. pre_delay = 0 skips PRE.
  - enable_o rises exactly pre_delay+1 cycles after the accepting clock edge.
- FRAME:
  - Lasts pulses*period cycles. Local cycle t runs 0..pulses*period-1.
  - enable_o = 1.
  - capture_o = 1 iff (t mod period) < width, so capture rises on the same edge as enable.
  - Implementation uses a period counter and a pulse counter; no multiplier or divider.
- GAP:
  - Lasts gap cycles with enable_o = 0 and capture_o = 0.
  - frame_cnt_o increments on entry to GAP.
  - If frame_cnt (after increment) == nframes and nframes != 0, go to DONE instead of FRAME.
  - The final frame still gets its gap.
- DONE:
  - One cycle; done_o = 1.
  - busy_o falls on the following edge, together with the return to IDLE.
- nframes = 0 (free-run): frame_cnt_o wraps modulo 2^CW and never terminates by count.

Abort:
- abort_i in any non-IDLE state forces IDLE on the next edge.
- enable_o, capture_o and busy_o go 0 that edge. done_o is not pulsed; frame_cnt_o holds its value.
- abort_i in IDLE has no effect.
- abort_i and start_i in the same cycle in IDLE: abort wins and start is dropped.

Reset mid-run: immediate return to the reset state, with no done or err pulse.

Decomposition:
- pcap_stim_pkg holds:
  - state enumeration (IDLE, PRE, FRAME, GAP, DONE);
  - the config-validity check as a function;
  - default parameter constants.
- One sub-module, stim_period_cnt: a loadable down-counter with terminal-count flag and CW-bit width. It is instantiated for the pre/gap delay, the period and the pulse count.

Test Plan:
- Basic frame:
  - Stimulus: nframes=1, pre=0, pulses=3, period=4, width=1, gap=2.
  - Response: enable high 12 cycles from start+1; capture high at t=0,4,8; done_o 15 cycles after start; frame_cnt_o=1.
- Pre-delay and multi-frame:
  - Stimulus: nframes=3, pre=5, pulses=2, period=3, width=2, gap=4.
  - Response: first enable edge at start+6; three 6-cycle enable windows separated by 4 low cycles; 6 captures of width 2 total; frame_cnt_o=3.
- Invalid config:
  - Stimulus: width=period=4, and separately pulses=0.
  - Response: err_o pulse at start+1; busy_o stays 0; outputs stay 0.
- Abort:
  - Stimulus: free-run (nframes=0); abort_i asserted during the second FRAME.
  - Response: enable/capture/busy low next edge; no done_o; frame_cnt_o=1.
- Mapping:
  - Stimulus: N_TTL=8, EN_IDX=7, CAP_IDX=3.
  - Response: ttl_o[7] matches enable_o and ttl_o[3] matches capture_o every cycle; all other bits 0.
- Reset and re-start:
  - Stimulus: assert reset_n_i low mid-FRAME, then restart with new config.
  - Response: all outputs 0 immediately; the new run obeys the new timing exactly; start_i while busy is ignored.

Source files
------------

// File: rtl/pcap_stim_pkg.sv
// Shared types, defaults and config validation for the framed enable/capture stimulus generator.
package pcap_stim_pkg;

    localparam int unsigned DEF_CW      = 32;
    localparam int unsigned DEF_N_TTL   = 6;
    localparam int unsigned DEF_EN_IDX  = 0;
    localparam int unsigned DEF_CAP_IDX = 2;

    typedef enum logic [2:0] {
        StIdle,
        StPre,
        StFrame,
        StGap,
        StDone
    } stim_state_e;

    // Fields are zero-extended to 64 bits so one function serves any CW up to 64.
    function automatic logic cfg_valid(input logic [63:0] period,
                                       input logic [63:0] width,
                                       input logic [63:0] pulses,
                                       input logic [63:0] gap);
        return (period >= 64'd2) && (width >= 64'd1) && (width < period) &&
               (pulses >= 64'd1) && (gap >= 64'd1);
    endfunction

endpackage

// File: rtl/stim_period_cnt.sv
// Loadable down-counter with a last-cycle flag; load has priority over decrement.
module stim_period_cnt #(
    parameter int unsigned CW = 32
) (
    input  logic          clk_i,
    input  logic          reset_n_i,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    input  logic          en_i,
    output logic [CW-1:0] cnt_o,
    output logic          tc_o
);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_cnt <= '0;
        end else if (load_i) begin
            r_cnt <= load_val_i;
        end else if (en_i && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign cnt_o = r_cnt;
    // Loaded with a duration N, the flag marks the N-th (final) cycle.
    assign tc_o  = (r_cnt == CW'(1));

endmodule

// File: rtl/pcap_stim_gen.sv
// Framed enable/capture pulse-train generator: PRE delay, then frames of capture pulses
// separated by enable-low gaps, with abort, completion and rejected-start reporting.
module pcap_stim_gen
    import pcap_stim_pkg::*;
#(
    parameter int unsigned CW      = DEF_CW,
    parameter int unsigned N_TTL   = DEF_N_TTL,
    parameter int unsigned EN_IDX  = DEF_EN_IDX,
    parameter int unsigned CAP_IDX = DEF_CAP_IDX
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [CW-1:0]    nframes_i,
    input  logic [CW-1:0]    pre_delay_i,
    input  logic [CW-1:0]    pulses_i,
    input  logic [CW-1:0]    period_i,
    input  logic [CW-1:0]    width_i,
    input  logic [CW-1:0]    gap_i,
    output logic [N_TTL-1:0] ttl_o,
    output logic             enable_o,
    output logic             capture_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [CW-1:0]    frame_cnt_o
);

    if ((EN_IDX == CAP_IDX) || (EN_IDX >= N_TTL) || (CAP_IDX >= N_TTL)) begin : g_bad_map
        $error("pcap_stim_gen: EN_IDX/CAP_IDX must differ and be below N_TTL");
    end
    if ((CW < 2) || (CW > 64)) begin : g_bad_cw
        $error("pcap_stim_gen: CW must be in 2..64");
    end

    stim_state_e   r_state, w_state_d;

    logic [CW-1:0] r_nframes, r_pulses, r_period, r_gap, r_per_minus_w;
    logic [CW-1:0] r_frame_cnt;
    logic          r_last;
    logic          r_enable, r_capture, r_busy, r_done, r_err;
    logic          w_enable_d, w_capture_d, w_busy_d, w_done_d, w_err_d;

    logic          w_start_ok, w_cfg_ok, w_accept, w_reject, w_abort;
    logic          w_frame_end, w_enter_frame;
    logic [CW-1:0] w_fcnt_inc;

    logic          w_dly_load, w_dly_en, w_dly_tc;
    logic          w_per_load, w_per_en, w_per_tc;
    logic          w_pul_load, w_pul_en, w_pul_tc;
    logic [CW-1:0] w_dly_val, w_per_val, w_pul_val;
    logic [CW-1:0] w_dly_cnt, w_per_cnt, w_pul_cnt;
    logic          w_unused;

    // r_busy spans every non-IDLE state plus the trailing done_o cycle.
    assign w_start_ok = start_i && !abort_i && (r_state == StIdle) && !r_busy;
    assign w_cfg_ok   = cfg_valid(64'(period_i), 64'(width_i), 64'(pulses_i), 64'(gap_i));
    assign w_accept   = w_start_ok && w_cfg_ok;
    assign w_reject   = w_start_ok && !w_cfg_ok;
    assign w_abort    = abort_i && r_busy;

    assign w_frame_end   = (r_state == StFrame) && w_per_tc && w_pul_tc;
    assign w_enter_frame = (w_accept && (pre_delay_i == '0)) ||
                           ((r_state == StPre) && w_dly_tc) ||
                           ((r_state == StGap) && w_dly_tc && !r_last);
    assign w_fcnt_inc    = r_frame_cnt + CW'(1);

    // The first load happens on the accepting edge, before the config registers are valid.
    assign w_dly_load = w_accept || w_frame_end;
    assign w_dly_val  = w_accept ? pre_delay_i : r_gap;
    assign w_dly_en   = (r_state == StPre) || (r_state == StGap);

    assign w_per_load = w_enter_frame || ((r_state == StFrame) && w_per_tc);
    assign w_per_val  = w_accept ? period_i : r_period;
    assign w_per_en   = (r_state == StFrame);

    assign w_pul_load = w_enter_frame;
    assign w_pul_val  = w_accept ? pulses_i : r_pulses;
    assign w_pul_en   = (r_state == StFrame) && w_per_tc;

    assign w_unused = ^{w_dly_cnt, w_pul_cnt};

    stim_period_cnt #(.CW(CW)) u_dly_cnt (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .load_i     (w_dly_load),
        .load_val_i (w_dly_val),
        .en_i       (w_dly_en),
        .cnt_o      (w_dly_cnt),
        .tc_o       (w_dly_tc)
    );

    stim_period_cnt #(.CW(CW)) u_per_cnt (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .load_i     (w_per_load),
        .load_val_i (w_per_val),
        .en_i       (w_per_en),
        .cnt_o      (w_per_cnt),
        .tc_o       (w_per_tc)
    );

    stim_period_cnt #(.CW(CW)) u_pul_cnt (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .load_i     (w_pul_load),
        .load_val_i (w_pul_val),
        .en_i       (w_pul_en),
        .cnt_o      (w_pul_cnt),
        .tc_o       (w_pul_tc)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        if (w_abort) begin
            w_state_d = StIdle;
        end else begin
            unique case (r_state)
                StIdle:  if (w_accept) w_state_d = (pre_delay_i == '0) ? StFrame : StPre;
                StPre:   if (w_dly_tc) w_state_d = StFrame;
                StFrame: if (w_frame_end) w_state_d = StGap;
                StGap:   if (w_dly_tc) w_state_d = r_last ? StDone : StFrame;
                StDone:  w_state_d = StIdle;
                default: w_state_d = StIdle;
            endcase
        end
    end

    // Pulse outputs follow the state by one register stage; busy and err react to the start edge.
    always_comb begin
        w_enable_d  = 1'b0;
        w_capture_d = 1'b0;
        w_done_d    = 1'b0;
        w_err_d     = 1'b0;
        w_busy_d    = r_busy;
        if (w_abort) begin
            w_busy_d = 1'b0;
        end else begin
            w_enable_d  = (r_state == StFrame);
            w_capture_d = (r_state == StFrame) && (w_per_cnt > r_per_minus_w);
            w_done_d    = (r_state == StDone);
            w_err_d     = w_reject;
            if (w_accept) begin
                w_busy_d = 1'b1;
            end else if (r_done) begin
                w_busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_enable  <= 1'b0;
            r_capture <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_enable  <= w_enable_d;
            r_capture <= w_capture_d;
            r_busy    <= w_busy_d;
            r_done    <= w_done_d;
            r_err     <= w_err_d;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_nframes     <= '0;
            r_pulses      <= '0;
            r_period      <= '0;
            r_gap         <= '0;
            r_per_minus_w <= '0;
            r_frame_cnt   <= '0;
            r_last        <= 1'b0;
        end else if (w_accept) begin
            r_nframes     <= nframes_i;
            r_pulses      <= pulses_i;
            r_period      <= period_i;
            r_gap         <= gap_i;
            r_per_minus_w <= period_i - width_i;
            r_frame_cnt   <= '0;
            r_last        <= 1'b0;
        end else if (w_frame_end && !w_abort) begin
            r_frame_cnt   <= w_fcnt_inc;
            r_last        <= (r_nframes != '0) && (w_fcnt_inc == r_nframes);
        end
    end

    always_comb begin
        ttl_o          = '0;
        ttl_o[EN_IDX]  = r_enable;
        ttl_o[CAP_IDX] = r_capture;
    end

    assign enable_o    = r_enable;
    assign capture_o   = r_capture;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign err_o       = r_err;
    assign frame_cnt_o = r_frame_cnt;

endmodule
